// File: rtl/seq_mult_pkg.sv
// -----------------------------------------------------------------------------
// seq_mult_pkg
//   Shared types and helpers for the sequential shift-add multiplier.
//   - state_e : controller states (IDLE -> RUN -> DONE -> IDLE)
//   - MAX_W   : widest operand the helpers support
//   - abs_w   : magnitude of a w-bit two's-complement value held in MAX_W bits
// -----------------------------------------------------------------------------
package seq_mult_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int unsigned MAX_W = 32;

    // x holds a w-bit value zero-extended to MAX_W bits. When its sign bit is
    // set the magnitude is 2^w - x, which for -2^(w-1) gives 2^(w-1) and still
    // fits in w unsigned bits. The extra top bit keeps w = MAX_W exact.
    function automatic logic [MAX_W-1:0] abs_w(input logic [MAX_W-1:0] x,
                                               input int unsigned     w);
        if (x[w-1])
            return MAX_W'((33'd1 << w) - {1'b0, x});
        else
            return x;
    endfunction

endpackage

// File: rtl/mult_shift_add_dp.sv
// -----------------------------------------------------------------------------
// mult_shift_add_dp
//   Unsigned shift-add datapath: holds the multiplicand, the multiplier shift
//   register and a 2W-bit accumulator. Each step adds the multiplicand into the
//   upper half when the multiplier LSB is set, then shifts {carry,acc,mplier}
//   right by one. After W steps acc holds the full unsigned product.
// Ports
//   clk, rst   : clock, asynchronous active-high reset
//   ld_i       : load mcand_i/mplier_i, clear accumulator
//   step_i     : perform one add/shift iteration
//   fin_i      : operation finished, clear internal state
//   mcand_i    : W-bit unsigned multiplicand
//   mplier_i   : W-bit unsigned multiplier
//   acc_o      : 2W-bit accumulator (product after W steps)
// -----------------------------------------------------------------------------
module mult_shift_add_dp
    import seq_mult_pkg::*;
#(
    parameter int unsigned W = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           ld_i,
    input  logic           step_i,
    input  logic           fin_i,
    input  logic [W-1:0]   mcand_i,
    input  logic [W-1:0]   mplier_i,
    output logic [2*W-1:0] acc_o
);

    logic [W-1:0]   mcand_q;
    logic [W-1:0]   mplier_q,  mplier_d;
    logic [2*W-1:0] acc_q,     acc_d;
    logic [W:0]     sum;

    // The carry out of the upper-half add becomes the new MSB after the shift,
    // and the bit leaving acc enters the top of the multiplier register.
    always_comb begin
        sum      = {1'b0, acc_q[2*W-1:W]} + {1'b0, (mplier_q[0] ? mcand_q : {W{1'b0}})};
        acc_d    = {sum, acc_q[W-1:1]};
        mplier_d = {acc_q[0], mplier_q[W-1:1]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
        end else if (ld_i) begin
            mcand_q  <= mcand_i;
            mplier_q <= mplier_i;
            acc_q    <= '0;
        end else if (step_i) begin
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
        end else if (fin_i) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/seq_mult_param.sv
// -----------------------------------------------------------------------------
// seq_mult_param
//   Sequential W x W -> 2W multiplier, unsigned or two's-complement per op.
//   Signed operands are reduced to magnitudes on capture; the sign of the
//   result is reapplied when the product register is written in DONE.
//   Fixed latency: start sampled at edge 0, done pulses after edge W+1.
// Ports
//   sys_clk     : clock
//   sys_rst     : asynchronous active-high reset (aborts any operation)
//   start       : request, sampled only in IDLE
//   signed_mode : 1 = two's-complement operation, sampled with start
//   a, b        : W-bit operands, sampled with start
//   busy        : high while RUN or DONE
//   done        : one-cycle pulse, product updated this cycle
//   product     : last completed 2W-bit result, held until next done
// -----------------------------------------------------------------------------
module seq_mult_param
    import seq_mult_pkg::*;
#(
    parameter int unsigned W = 4
) (
    input  logic           sys_clk,
    input  logic           sys_rst,
    input  logic           start,
    input  logic           signed_mode,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic           busy,
    output logic           done,
    output logic [2*W-1:0] product
);

    localparam int unsigned CW = $clog2(W + 1);

    state_e         state_q;
    logic [CW-1:0]  cnt_q,  cnt_d;
    logic           neg_q,  neg_d;
    logic           busy_q;
    logic           done_q;
    logic [2*W-1:0] product_q, product_d;

    logic           ld, step, fin;
    logic [W-1:0]   mcand_in, mplier_in;
    logic [2*W-1:0] acc;

    // Magnitudes are only taken in signed mode; unsigned operands pass through.
    assign mcand_in  = signed_mode ? W'(abs_w(MAX_W'(a), W)) : a;
    assign mplier_in = signed_mode ? W'(abs_w(MAX_W'(b), W)) : b;

    assign ld   = (state_q == ST_IDLE) && start;
    assign step = (state_q == ST_RUN);
    assign fin  = (state_q == ST_DONE);

    assign neg_d     = signed_mode & (a[W-1] ^ b[W-1]);
    assign cnt_d     = cnt_q + CW'(1);
    assign product_d = neg_q ? (~acc + 1'b1) : acc;

    mult_shift_add_dp #(.W(W)) u_dp (
        .clk      (sys_clk),
        .rst      (sys_rst),
        .ld_i     (ld),
        .step_i   (step),
        .fin_i    (fin),
        .mcand_i  (mcand_in),
        .mplier_i (mplier_in),
        .acc_o    (acc)
    );

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            neg_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            product_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        neg_q   <= neg_d;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    cnt_q <= cnt_d;
                    if (cnt_q == CW'(W - 1))
                        state_q <= ST_DONE;
                end
                ST_DONE: begin
                    product_q <= product_d;
                    done_q    <= 1'b1;
                    busy_q    <= 1'b0;
                    neg_q     <= 1'b0;
                    cnt_q     <= '0;
                    state_q   <= ST_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign product = product_q;

endmodule

// File: tb/tb_seq_mult_param.sv
// -----------------------------------------------------------------------------
// tb_seq_mult_param
//   Bench for seq_mult_param at W=4 (vector table, random ops, back-to-back
//   start, mid-op reset) and W=8 (random sweep plus corners). Expected
//   products come from plain integer multiplication of the operands.
// -----------------------------------------------------------------------------
module tb_seq_mult_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        start4, sm4, busy4, done4;
    logic [3:0]  a4, b4;
    logic [7:0]  prod4;
    logic        start8, sm8, busy8, done8;
    logic [7:0]  a8, b8;
    logic [15:0] prod8;

    int n_tests = 0;
    int n_fail  = 0;

    seq_mult_param #(.W(4)) u4 (
        .sys_clk(clk), .sys_rst(rst), .start(start4), .signed_mode(sm4),
        .a(a4), .b(b4), .busy(busy4), .done(done4), .product(prod4)
    );

    seq_mult_param #(.W(8)) u8 (
        .sys_clk(clk), .sys_rst(rst), .start(start8), .signed_mode(sm8),
        .a(a8), .b(b8), .busy(busy8), .done(done8), .product(prod8)
    );

    typedef struct {
        bit         sm;
        logic [3:0] a;
        logic [3:0] b;
        logic [7:0] exp;
    } vec_t;

    vec_t tbl [12];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: interpret operands as w-bit signed or unsigned integers and
    // multiply, then keep the low 2w bits.
    function automatic logic [63:0] ref_mul(input int w, input bit sm,
                                            input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, p;
        logic [63:0] m;
        m  = (64'd1 << w) - 64'd1;
        sa = longint'(64'(a) & m);
        sb = longint'(64'(b) & m);
        if (sm && sa[w-1]) sa = sa - (longint'(1) << w);
        if (sm && sb[w-1]) sb = sb - (longint'(1) << w);
        p = sa * sb;
        return 64'(p) & ((64'd1 << (2 * w)) - 64'd1);
    endfunction

    function automatic logic busy_of(input int w);
        return (w == 4) ? busy4 : busy8;
    endfunction
    function automatic logic done_of(input int w);
        return (w == 4) ? done4 : done8;
    endfunction
    function automatic logic [15:0] prod_of(input int w);
        return (w == 4) ? {8'h00, prod4} : prod8;
    endfunction

    // One complete operation: start for one cycle, scramble operands while
    // busy, check latency, product, single-cycle done and product hold.
    task automatic run_op(input int w, input bit sm, input logic [7:0] a,
                          input logic [7:0] b, input logic [15:0] exp, input string tag);
        int got_k;
        @(negedge clk);
        if (w == 4) begin start4 = 1'b1; sm4 = sm; a4 = a[3:0]; b4 = b[3:0]; end
        else        begin start8 = 1'b1; sm8 = sm; a8 = a;      b8 = b;      end
        @(posedge clk); #1;
        start4 = 1'b0; start8 = 1'b0;
        if (w == 4) begin a4 = 4'($urandom); b4 = 4'($urandom); sm4 = ~sm; end
        else        begin a8 = 8'($urandom); b8 = 8'($urandom); sm8 = ~sm; end
        chk({tag, " busy_after_start"}, 64'(busy_of(w)), 64'd1);
        got_k = -1;
        for (int k = 1; k <= 3 * w; k++) begin
            @(posedge clk); #1;
            if (done_of(w)) begin
                got_k = k;
                break;
            end
        end
        chk({tag, " done_latency"}, 64'(got_k), 64'(w + 1));
        if (got_k > 0) begin
            chk({tag, " product"}, 64'(prod_of(w)), 64'(exp));
            chk({tag, " busy_at_done"}, 64'(busy_of(w)), 64'd0);
            @(posedge clk); #1;
            chk({tag, " done_one_cycle"}, 64'(done_of(w)), 64'd0);
            chk({tag, " product_hold"}, 64'(prod_of(w)), 64'(exp));
        end
    endtask

    initial begin
        int ndone, first_k, second_k;
        logic [7:0] ra, rb;
        bit rs;

        tbl[0]  = '{1'b0, 4'hF, 4'hF, 8'hE1};
        tbl[1]  = '{1'b1, 4'h8, 4'h8, 8'h40};
        tbl[2]  = '{1'b1, 4'hD, 4'h5, 8'hF1};
        tbl[3]  = '{1'b1, 4'hF, 4'h0, 8'h00};
        tbl[4]  = '{1'b0, 4'h0, 4'h9, 8'h00};
        tbl[5]  = '{1'b1, 4'h8, 4'h7, 8'hC8};
        tbl[6]  = '{1'b0, 4'h8, 4'h8, 8'h40};
        tbl[7]  = '{1'b1, 4'h7, 4'h7, 8'h31};
        tbl[8]  = '{1'b1, 4'hF, 4'hF, 8'h01};
        tbl[9]  = '{1'b1, 4'h8, 4'h1, 8'hF8};
        tbl[10] = '{1'b0, 4'hF, 4'h1, 8'h0F};
        tbl[11] = '{1'b1, 4'h7, 4'h8, 8'hC8};

        rst = 1'b1;
        start4 = 1'b0; sm4 = 1'b0; a4 = '0; b4 = '0;
        start8 = 1'b0; sm8 = 1'b0; a8 = '0; b8 = '0;
        #1;
        chk("reset busy4", 64'(busy4), 64'd0);
        chk("reset done4", 64'(done4), 64'd0);
        chk("reset prod4", 64'(prod4), 64'd0);
        chk("reset busy8", 64'(busy8), 64'd0);
        chk("reset done8", 64'(done8), 64'd0);
        chk("reset prod8", 64'(prod8), 64'd0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;

        // W=4 vector table
        for (int i = 0; i < 12; i++)
            run_op(4, tbl[i].sm, {4'h0, tbl[i].a}, {4'h0, tbl[i].b}, {8'h00, tbl[i].exp},
                   $sformatf("w4_vec%0d", i));

        // W=4 random ops
        for (int i = 0; i < 10; i++) begin
            ra = 8'($urandom_range(0, 15)); rb = 8'($urandom_range(0, 15)); rs = 1'($urandom);
            run_op(4, rs, ra, rb, 16'(ref_mul(4, rs, 32'(ra), 32'(rb))), $sformatf("w4_rnd%0d", i));
        end

        // start held for 12 cycles: exactly two ops, results unaffected by
        // operand changes while busy
        @(negedge clk);
        start4 = 1'b1; a4 = 4'd3; b4 = 4'd2; sm4 = 1'b0;
        @(posedge clk); #1;
        ndone = 0; first_k = -1; second_k = -1;
        for (int k = 1; k <= 16; k++) begin
            if ((k >= 1 && k <= 4) || (k >= 7 && k <= 10)) begin
                a4 = 4'($urandom); b4 = 4'($urandom); sm4 = 1'b1;
            end else begin
                a4 = 4'd3; b4 = 4'd2; sm4 = 1'b0;
            end
            start4 = (k <= 11);
            @(posedge clk); #1;
            if (done4) begin
                ndone++;
                if (first_k < 0) first_k = k; else if (second_k < 0) second_k = k;
                chk($sformatf("held_start product@%0d", k), 64'(prod4), 64'd6);
            end
        end
        start4 = 1'b0;
        chk("held_start done_count", 64'(ndone), 64'd2);
        chk("held_start first_done", 64'(first_k), 64'd5);
        chk("held_start done_gap", 64'(second_k - first_k), 64'd6);

        // reset in the middle of RUN aborts without a done pulse
        @(negedge clk);
        start4 = 1'b1; a4 = 4'd7; b4 = 4'd7; sm4 = 1'b0;
        @(posedge clk); #1;
        start4 = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("midrst busy_before", 64'(busy4), 64'd1);
        rst = 1'b1;
        #1;
        chk("midrst busy", 64'(busy4), 64'd0);
        chk("midrst prod", 64'(prod4), 64'd0);
        chk("midrst done", 64'(done4), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            if (done4 || busy4) ndone++;
        end
        chk("midrst no_done_no_busy", 64'(ndone), 64'd0);
        run_op(4, 1'b0, 8'd2, 8'd3, 16'd6, "after_rst");

        // W=8 corners and random sweep
        run_op(8, 1'b1, 8'h80, 8'h80, 16'h4000, "w8_minmin");
        run_op(8, 1'b0, 8'hFF, 8'hFF, 16'hFE01, "w8_maxmax");
        run_op(8, 1'b1, 8'h80, 8'h7F, 16'hC080, "w8_minmax");
        for (int i = 0; i < 30; i++) begin
            ra = 8'($urandom); rb = 8'($urandom); rs = 1'($urandom);
            run_op(8, rs, ra, rb, 16'(ref_mul(8, rs, 32'(ra), 32'(rb))), $sformatf("w8_rnd%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
